// File: rtl/gpi_scan_pkg.sv
// gpi_scan_pkg: register map offsets, field positions and the debounce state
// type shared by the GPI scan controller and its per-channel debounce FSM.
package gpi_scan_pkg;

    // Register index = PADDR[4:2]
    localparam logic [2:0] REG_CR  = 3'd0;
    localparam logic [2:0] REG_PSC = 3'd1;
    localparam logic [2:0] REG_DBC = 3'd2;
    localparam logic [2:0] REG_IDR = 3'd3;
    localparam logic [2:0] REG_IER = 3'd4;
    localparam logic [2:0] REG_ISR = 3'd5;

    localparam int CR_SMP_BIT   = 16;
    localparam int ISR_RISE_LSB = 0;
    localparam int ISR_FALL_LSB = 16;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_CHANGING = 1'b1
    } db_state_e;

endpackage

// File: rtl/gpi_debounce_ch.sv
// gpi_debounce_ch: debounce FSM for one synchronised GPI channel.
// Ports: PCLK, PRESET (async, active-high); sync_in (2-flop synced pin),
//   tick (sample strobe), en (channel enable), dbc (debounce count);
//   stable (debounced value), rise/fall (one-cycle commit pulses).
// Used by gpi_scan_ctrl; rise/fall are consumed only when GPI_EDGE_IRQ_EN is defined.
module gpi_debounce_ch
    import gpi_scan_pkg::*;
#(
    parameter int DB_W = 4
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic            sync_in,
    input  logic            tick,
    input  logic            en,
    input  logic [DB_W-1:0] dbc,
    output logic            stable,
    output logic            rise,
    output logic            fall
);

    db_state_e       state, state_nx;
    logic [DB_W-1:0] dcnt, dcnt_nx;
    logic            stable_nx;
    logic            mismatch;
    logic            commit;

    assign mismatch = sync_in != stable;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state  <= DB_STABLE;
            dcnt   <= '0;
            stable <= 1'b0;
        end else begin
            state  <= state_nx;
            dcnt   <= dcnt_nx;
            stable <= stable_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        dcnt_nx   = dcnt;
        stable_nx = stable;
        if (!en) begin
            // Disabled channel follows the pin so enabling it never fires an edge
            state_nx  = DB_STABLE;
            dcnt_nx   = '0;
            stable_nx = sync_in;
        end else if (commit) begin
            state_nx  = DB_STABLE;
            stable_nx = sync_in;
        end else if (tick) begin
            unique case (state)
                DB_STABLE: begin
                    if (mismatch) begin
                        state_nx = DB_CHANGING;
                        dcnt_nx  = DB_W'(1);
                    end
                end
                DB_CHANGING: begin
                    if (!mismatch)
                        state_nx = DB_STABLE;
                    else
                        dcnt_nx = dcnt + DB_W'(1);
                end
                default: ;
            endcase
        end
    end

    // >= so a DBC lowered mid-debounce commits on the next mismatching tick
    always_comb begin
        commit = 1'b0;
        if (en && tick && mismatch) begin
            unique case (state)
                DB_STABLE:   commit = dbc == '0;
                DB_CHANGING: commit = dcnt >= dbc;
                default:     commit = 1'b0;
            endcase
        end
        rise = commit && sync_in;
        fall = commit && !sync_in;
    end

endmodule

// File: rtl/gpi_scan_ctrl.sv
// gpi_scan_ctrl: APB slave sampling GPI pins through a 2-flop sync, a prescaled
// tick and per-channel debounce; optional edge IRQ when GPI_EDGE_IRQ_EN is defined.
// Ports: PCLK, PRESET (async, active-high), APB (PADDR/PWRITE/PENABLE/PWDATA/
//   PSEL in, PRDATA/PREADY out, registered), gpi (async pins), irq (level, registered).
module gpi_scan_ctrl
    import gpi_scan_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int PSC_W = 16,
    parameter int DB_W  = 4
) (
    input  logic           PCLK,
    input  logic           PRESET,
    input  logic [4:0]     PADDR,
    input  logic           PWRITE,
    input  logic           PENABLE,
    input  logic [31:0]    PWDATA,
    input  logic           PSEL,
    output logic [31:0]    PRDATA,
    output logic           PREADY,
    input  logic [NCH-1:0] gpi,
    output logic           irq
);

    logic             acc, wr_en, psc_wr, tick;
    logic [2:0]       reg_sel;
    logic [31:0]      rd_data;
    logic [NCH-1:0]   cr_en;
    logic             cr_smp;
    logic [PSC_W-1:0] psc, cnt;
    logic [DB_W-1:0]  dbc;
    logic [NCH-1:0]   sync1, sync2;
    logic [NCH-1:0]   stable_v, rise_v, fall_v;

    // One wait state: access completes on the edge after PENABLE rises
    assign acc     = PSEL && PENABLE && !PREADY;
    assign wr_en   = acc && PWRITE;
    assign reg_sel = PADDR[4:2];
    assign psc_wr  = wr_en && reg_sel == REG_PSC;
    assign tick    = cr_smp && cnt == psc;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PREADY <= 1'b0;
            PRDATA <= '0;
            cr_en  <= '0;
            cr_smp <= 1'b0;
            psc    <= '0;
            dbc    <= '0;
        end else begin
            PREADY <= acc;
            if (acc && !PWRITE)
                PRDATA <= rd_data;
            if (wr_en) begin
                case (reg_sel)
                    REG_CR: begin
                        cr_en  <= PWDATA[NCH-1:0];
                        cr_smp <= PWDATA[CR_SMP_BIT];
                    end
                    REG_PSC: psc <= PWDATA[PSC_W-1:0];
                    REG_DBC: dbc <= PWDATA[DB_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            cnt <= '0;
        else if (!cr_smp || psc_wr || cnt == psc)
            cnt <= '0;
        else
            cnt <= cnt + PSC_W'(1);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= gpi;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        gpi_debounce_ch #(
            .DB_W(DB_W)
        ) u_ch (
            .PCLK   (PCLK),
            .PRESET (PRESET),
            .sync_in(sync2[i]),
            .tick   (tick),
            .en     (cr_en[i]),
            .dbc    (dbc),
            .stable (stable_v[i]),
            .rise   (rise_v[i]),
            .fall   (fall_v[i])
        );
    end

`ifdef GPI_EDGE_IRQ_EN
    logic [NCH-1:0] ier_r, ier_f, isr_r, isr_f;
    logic [NCH-1:0] w1c_r, w1c_f;
    logic           isr_wr;

    assign isr_wr = wr_en && reg_sel == REG_ISR;
    assign w1c_r  = isr_wr ? PWDATA[ISR_RISE_LSB +: NCH] : '0;
    assign w1c_f  = isr_wr ? PWDATA[ISR_FALL_LSB +: NCH] : '0;

    // Set has priority over a same-cycle write-1-to-clear
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ier_r <= '0;
            ier_f <= '0;
            isr_r <= '0;
            isr_f <= '0;
            irq   <= 1'b0;
        end else begin
            if (wr_en && reg_sel == REG_IER) begin
                ier_r <= PWDATA[ISR_RISE_LSB +: NCH];
                ier_f <= PWDATA[ISR_FALL_LSB +: NCH];
            end
            isr_r <= (isr_r & ~w1c_r) | rise_v;
            isr_f <= (isr_f & ~w1c_f) | fall_v;
            irq   <= |{isr_r & ier_r, isr_f & ier_f};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{PADDR[1:0], PWDATA};
`else
    assign irq = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{PADDR[1:0], PWDATA, rise_v, fall_v};
`endif

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CR: begin
                rd_data[NCH-1:0]  = cr_en;
                rd_data[CR_SMP_BIT] = cr_smp;
            end
            REG_PSC: rd_data[PSC_W-1:0] = psc;
            REG_DBC: rd_data[DB_W-1:0]  = dbc;
            REG_IDR: rd_data[NCH-1:0]   = stable_v & cr_en;
`ifdef GPI_EDGE_IRQ_EN
            REG_IER: begin
                rd_data[ISR_RISE_LSB +: NCH] = ier_r;
                rd_data[ISR_FALL_LSB +: NCH] = ier_f;
            end
            REG_ISR: begin
                rd_data[ISR_RISE_LSB +: NCH] = isr_r;
                rd_data[ISR_FALL_LSB +: NCH] = isr_f;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gpi_scan_ctrl.sv
// tb_gpi_scan_ctrl: self-checking bench for gpi_scan_ctrl (NCH=8).
// APB read expectations are queued at issue and compared when PREADY returns.
module tb_gpi_scan_ctrl;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [4:0]  PADDR = '0;
    logic        PWRITE = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic        PSEL = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic [7:0]  gpi = '0;
    logic        irq;

`ifdef GPI_EDGE_IRQ_EN
    localparam logic [31:0] IRQ_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] IRQ_MASK = 32'h0;
`endif

    gpi_scan_ctrl #(.NCH(8), .PSC_W(16), .DB_W(4)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .PADDR  (PADDR),
        .PWRITE (PWRITE),
        .PENABLE(PENABLE),
        .PWDATA (PWDATA),
        .PSEL   (PSEL),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .gpi    (gpi),
        .irq    (irq)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [17];
    logic [31:0] sbq [$];
    string       nq  [$];
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h want %h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic apb(input bit wr, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string nm);
        int          n;
        logic [31:0] ex;
        string       en;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        if (!wr) begin
            sbq.push_back(e);
            nq.push_back(nm);
        end
        @(negedge PCLK);
        PENABLE = 1'b1;
        n = 0;
        do begin
            @(posedge PCLK); #1;
            n++;
        end while (!PREADY && n < 4);
        chk({nm, "_pready"}, 32'(PREADY), 32'd1);
        if (!wr) begin
            ex = sbq.pop_front();
            en = nq.pop_front();
            chk(en, PRDATA, ex);
        end
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        chk({nm, "_pready_lo"}, 32'(PREADY), 32'd0);
    endtask

    task automatic rd_lat(input int j, input logic val, input logic [31:0] e, input string nm);
        @(negedge PCLK);
        gpi[0] = val;
        repeat (j - 1) @(negedge PCLK);
        apb(1'b0, 5'h0C, 32'h0, e, nm);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'h00, 32'h0001_00FF, 32'h0};
        tbl[1]  = '{1'b0, 5'h00, 32'h0,         32'h0001_00FF};
        tbl[2]  = '{1'b1, 5'h18, 32'hDEAD_BEEF, 32'h0};
        tbl[3]  = '{1'b0, 5'h18, 32'h0,         32'h0};
        tbl[4]  = '{1'b0, 5'h00, 32'h0,         32'h0001_00FF};
        tbl[5]  = '{1'b1, 5'h04, 32'h000A_BCDE, 32'h0};
        tbl[6]  = '{1'b0, 5'h04, 32'h0,         32'h0000_BCDE};
        tbl[7]  = '{1'b1, 5'h08, 32'hFFFF_FFF7, 32'h0};
        tbl[8]  = '{1'b0, 5'h08, 32'h0,         32'h0000_0007};
        tbl[9]  = '{1'b1, 5'h0C, 32'h0000_00FF, 32'h0};
        tbl[10] = '{1'b0, 5'h0C, 32'h0,         32'h0};
        tbl[11] = '{1'b1, 5'h10, 32'hFFFF_FFFF, 32'h0};
        tbl[12] = '{1'b0, 5'h10, 32'h0,         32'h00FF_00FF & IRQ_MASK};
        tbl[13] = '{1'b0, 5'h14, 32'h0,         32'h0};
        tbl[14] = '{1'b1, 5'h00, 32'hFFFF_FFFF, 32'h0};
        tbl[15] = '{1'b0, 5'h00, 32'h0,         32'h0001_00FF};
        tbl[16] = '{1'b0, 5'h1C, 32'h0,         32'h0};

        // Reset state
        wait_cyc(3);
        #1;
        chk("rst_pready", 32'(PREADY), 32'd0);
        chk("rst_prdata", PRDATA, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int i = 0; i < 6; i++)
            apb(1'b0, 5'(i * 4), 32'h0, 32'h0, $sformatf("rst_reg%0d", i));

        // Register map vectors
        for (int i = 0; i < 17; i++)
            apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("vec%0d", i));

        // Pin-to-IDR latency with PSC=0, DBC=0
        apb(1'b1, 5'h04, 32'h0, 32'h0, "lat_psc");
        apb(1'b1, 5'h08, 32'h0, 32'h0, "lat_dbc");
        apb(1'b1, 5'h00, 32'h0001_0001, 32'h0, "lat_cr");
        apb(1'b1, 5'h14, 32'hFFFF_FFFF, 32'h0, "lat_clr");
        rd_lat(1, 1'b1, 32'h0, "lat_rise_e3");
        wait_cyc(5);
        apb(1'b0, 5'h0C, 32'h0, 32'h1, "lat_rise_done");
        apb(1'b0, 5'h14, 32'h0, 32'h1 & IRQ_MASK, "lat_isr_rise");
        chk("lat_irq", 32'(irq), 32'(IRQ_MASK[0]));
        rd_lat(1, 1'b0, 32'h1, "lat_fall_e3");
        wait_cyc(5);
        rd_lat(2, 1'b1, 32'h1, "lat_rise_e4");
        wait_cyc(5);

        // Debounce: 2-tick glitch dropped, 3-tick level committed
        apb(1'b1, 5'h04, 32'h4, 32'h0, "db_psc");
        apb(1'b1, 5'h08, 32'h2, 32'h0, "db_dbc");
        apb(1'b1, 5'h00, 32'h0001_0002, 32'h0, "db_cr");
        apb(1'b1, 5'h14, 32'hFFFF_FFFF, 32'h0, "db_clr");
        @(negedge PCLK);
        gpi[1] = 1'b1;
        wait_cyc(10);
        gpi[1] = 1'b0;
        wait_cyc(20);
        apb(1'b0, 5'h0C, 32'h0, 32'h0, "db_glitch_idr");
        apb(1'b0, 5'h14, 32'h0, 32'h0, "db_glitch_isr");
        @(negedge PCLK);
        gpi[1] = 1'b1;
        wait_cyc(20);
        apb(1'b0, 5'h0C, 32'h0, 32'h2, "db_commit_idr");
        apb(1'b0, 5'h14, 32'h0, 32'h2 & IRQ_MASK, "db_commit_isr");

        // Fall interrupt and W1C
        apb(1'b1, 5'h04, 32'h0, 32'h0, "fi_psc");
        apb(1'b1, 5'h08, 32'h0, 32'h0, "fi_dbc");
        apb(1'b1, 5'h00, 32'h0001_0001, 32'h0, "fi_cr");
        apb(1'b1, 5'h10, 32'h0001_0000, 32'h0, "fi_ier");
        apb(1'b1, 5'h14, 32'hFFFF_FFFF, 32'h0, "fi_clr");
        wait_cyc(2);
        chk("fi_irq_idle", 32'(irq), 32'd0);
        gpi[0] = 1'b0;
        wait_cyc(5);
        chk("fi_irq_set", 32'(irq), 32'(IRQ_MASK[0]));
        apb(1'b0, 5'h14, 32'h0, 32'h0001_0000 & IRQ_MASK, "fi_isr");
        apb(1'b1, 5'h14, 32'h0001_0000, 32'h0, "fi_w1c");
        chk("fi_irq_clr", 32'(irq), 32'd0);
        apb(1'b0, 5'h14, 32'h0, 32'h0, "fi_isr_clr");

        // Disabled channel tracks its pin and raises no flags
        apb(1'b1, 5'h00, 32'h0001_0000, 32'h0, "dis_cr");
        apb(1'b1, 5'h14, 32'hFFFF_FFFF, 32'h0, "dis_clr");
        for (int i = 0; i < 7; i++) begin
            @(negedge PCLK);
            gpi[3] = ~gpi[3];
            wait_cyc(2);
        end
        wait_cyc(5);
        apb(1'b1, 5'h00, 32'h0001_0008, 32'h0, "dis_en");
        wait_cyc(5);
        apb(1'b0, 5'h0C, 32'h0, 32'h8, "dis_idr");
        apb(1'b0, 5'h14, 32'h0, 32'h0, "dis_isr");
        chk("dis_irq", 32'(irq), 32'd0);

        // Reset in the middle of a debounce
        apb(1'b1, 5'h04, 32'h3, 32'h0, "mr_psc");
        apb(1'b1, 5'h08, 32'h5, 32'h0, "mr_dbc");
        apb(1'b1, 5'h00, 32'h0001_00FF, 32'h0, "mr_cr");
        apb(1'b1, 5'h10, 32'hFFFF_FFFF, 32'h0, "mr_ier");
        apb(1'b0, 5'h00, 32'h0, 32'h0001_00FF, "mr_pre");
        @(negedge PCLK);
        gpi[2] = 1'b1;
        wait_cyc(10);
        PRESET = 1'b1;
        #1;
        chk("mr_pready", 32'(PREADY), 32'd0);
        chk("mr_prdata", PRDATA, 32'h0);
        chk("mr_irq", 32'(irq), 32'd0);
        wait_cyc(2);
        PRESET = 1'b0;
        for (int i = 0; i < 6; i++)
            apb(1'b0, 5'(i * 4), 32'h0, 32'h0, $sformatf("mr_reg%0d", i));
        chk("mr_irq_after", 32'(irq), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
